// File: rtl/coeff_load_ctrl.sv
// coeff_load_ctrl: loads a bank of N_TAP signed coefficients into a shadow
// register over a valid/ready stream. It then commits the bank to the
// decimator with a single-cycle write strobe, and can optionally verify the
// decimator's readback.
//
// Build option: define COEFF_LOAD_VERIFY_EN to include the VERIFY state and
// the readback compare. Without it, COMMIT returns straight to IDLE, done
// arrives one cycle earlier, verify_err stays 0 and coeff_rb is ignored.
//
// Handshake: a coefficient word moves on a rising edge where
// cfg_valid && cfg_ready. cfg_ready is high only in LOAD. Taps arrive in order
// 0..N_TAP-1. A same-cycle cfg_abort wins, and that word is dropped.
//
// Bank layout: tap k occupies bits [k*COEFF_WIDTH +: COEFF_WIDTH] of both
// coeff_bank and coeff_rb.
module coeff_load_ctrl #(
  parameter int COEFF_WIDTH  = 20,
  parameter int N_TAP        = 72,
  parameter int SAFE_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [COEFF_WIDTH-1:0]       cfg_data,
  input  logic                         filt_valid_in,
  input  logic [COEFF_WIDTH*N_TAP-1:0] coeff_rb,
  output logic [COEFF_WIDTH*N_TAP-1:0] coeff_bank,
  output logic                         coeff_wr_en,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic                         forced_commit,
  output logic                         verify_err,
  output logic [2:0]                   o_dbg_state
);

  localparam int IDX_W = (N_TAP > 1) ? $clog2(N_TAP) : 1;
  localparam int CNT_W = (SAFE_TIMEOUT > 1) ? $clog2(SAFE_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAP - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAFE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_SAFE = 3'd2,
    S_COMMIT    = 3'd3,
    S_VERIFY    = 3'd4
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [IDX_W-1:0]               r_idx;
  logic [IDX_W-1:0]               w_next_idx;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_next_cnt;
  logic [COEFF_WIDTH*N_TAP-1:0]   r_shadow;
  logic                           r_done;
  logic                           r_aborted;
  logic                           r_forced;
  logic                           r_verr;
  logic                           w_write;
  logic                           w_done_nxt;
  logic                           w_abort_nxt;
  logic                           w_forced_nxt;
  logic                           w_verr_nxt;
  logic                           w_mismatch;

`ifdef COEFF_LOAD_VERIFY_EN
  // The shadow and the readback use the same layout, so a single vector
  // compare is the same as comparing every tap.
  assign w_mismatch = (coeff_rb != r_shadow);
`else
  logic w_unused_rb;
  assign w_unused_rb = ^coeff_rb;
  assign w_mismatch  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic and next values for the index, the counter and the flags.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_cnt   = r_cnt;
    w_write      = 1'b0;
    w_done_nxt   = 1'b0;
    w_abort_nxt  = 1'b0;
    w_forced_nxt = r_forced;
    w_verr_nxt   = r_verr;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_next_state = S_LOAD;
          w_next_idx   = '0;
          w_forced_nxt = 1'b0;
          w_verr_nxt   = 1'b0;
        end
      end
      S_LOAD: begin
        if (cfg_abort) begin
          w_next_state = S_IDLE;
          w_abort_nxt  = 1'b1;
        end else if (cfg_valid) begin
          w_write = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_next_state = S_WAIT_SAFE;
            w_next_cnt   = '0;
          end else begin
            w_next_idx = r_idx + 1'b1;
          end
        end
      end
      S_WAIT_SAFE: begin
        if (cfg_abort) begin
          w_next_state = S_IDLE;
          w_abort_nxt  = 1'b1;
        end else if (!filt_valid_in) begin
          w_next_state = S_COMMIT;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_COMMIT;
          w_forced_nxt = 1'b1;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      S_COMMIT: begin
`ifdef COEFF_LOAD_VERIFY_EN
        w_next_state = S_VERIFY;
`else
        w_next_state = S_IDLE;
        w_done_nxt   = 1'b1;
`endif
      end
      S_VERIFY: begin
        if (w_mismatch) w_verr_nxt = 1'b1;
        w_next_state = S_IDLE;
        w_done_nxt   = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Tap index, wait counter, the done/aborted pulses and the sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_forced  <= 1'b0;
      r_verr    <= 1'b0;
    end else begin
      r_idx     <= w_next_idx;
      r_cnt     <= w_next_cnt;
      r_done    <= w_done_nxt;
      r_aborted <= w_abort_nxt;
      r_forced  <= w_forced_nxt;
      r_verr    <= w_verr_nxt;
    end
  end

  // Shadow bank: only an accepted LOAD handshake writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int k = 0; k < N_TAP; k++) begin
        if (w_write && (r_idx == IDX_W'(k)))
          r_shadow[k*COEFF_WIDTH +: COEFF_WIDTH] <= cfg_data;
      end
    end
  end

  assign cfg_ready     = (r_state == S_LOAD);
  assign busy          = (r_state != S_IDLE);
  assign coeff_wr_en   = (r_state == S_COMMIT);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign forced_commit = r_forced;
  assign verify_err    = r_verr;
  assign coeff_bank    = r_shadow;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Directed testbench for coeff_load_ctrl (default parameters). It models a
// decimator that loops the committed bank back on coeff_rb one cycle after
// coeff_wr_en. It can also corrupt tap 5 of that readback.
module tb_coeff_load_ctrl;
  localparam int W  = 20;
  localparam int N  = 72;
  localparam int TO = 16;
`ifdef COEFF_LOAD_VERIFY_EN
  localparam int       DONE_OFS = 2;
  localparam bit       VER      = 1'b1;
`else
  localparam int       DONE_OFS = 1;
  localparam bit       VER      = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_start, cfg_abort, cfg_valid, cfg_ready;
  logic [W-1:0]   cfg_data;
  logic           filt_valid_in;
  logic [W*N-1:0] coeff_rb;
  logic [W*N-1:0] coeff_bank;
  logic           coeff_wr_en, busy, done, aborted, forced_commit, verify_err;
  logic [2:0]     o_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int w0, d0, a0;
  logic wr_prev;
  logic corrupt5;
  logic [W-1:0] exp_bank[N];

  coeff_load_ctrl #(.COEFF_WIDTH(W), .N_TAP(N), .SAFE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .filt_valid_in(filt_valid_in), .coeff_rb(coeff_rb), .coeff_bank(coeff_bank),
    .coeff_wr_en(coeff_wr_en), .busy(busy), .done(done), .aborted(aborted),
    .forced_commit(forced_commit), .verify_err(verify_err),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one clock. Outputs are sampled 1 ns after the edge. The readback
  // model and the pulse counters are updated here too.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_prev) begin
      coeff_rb = coeff_bank;
      if (corrupt5) coeff_rb[5*W +: W] = '0;
    end
    wr_prev = coeff_wr_en;
    if (coeff_wr_en) wr_cnt++;
    if (done)        done_cnt++;
    if (aborted)     abort_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < N; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(coeff_bank[k*W +: W]), 32'(exp_bank[k]));
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Send taps 0..n-1 back to back with value base+k, and pulse cfg_start on tap start_at.
  task automatic load_taps(input int n, input int base, input int start_at);
    for (int k = 0; k < n; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = W'(base + k);
      cfg_start = (k == start_at);
      tick();
      exp_bank[k] = W'(base + k);
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
  endtask

  // Starts one cycle after the last handshake edge. Records the cycle of
  // coeff_wr_en and the cycle of done, and stops after 60 cycles.
  task automatic finish_load(input int exp_wr, input bit abort_in_commit, input string tag);
    int c = 1;
    int wr_c = 0;
    int done_c = 0;
    while (done_c == 0 && c < 60) begin
      if (coeff_wr_en && wr_c == 0) wr_c = c;
      if (done) done_c = c;
      cfg_abort = abort_in_commit && (wr_c != 0) && (done_c == 0);
      if (done_c == 0) begin
        tick();
        c++;
      end
    end
    cfg_abort = 1'b0;
    check({tag, "_wr_cycle"}, 32'(wr_c), 32'(exp_wr));
    check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_wr + DONE_OFS));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  32'(cfg_ready),     32'd0);
    check({tag, "_wr_en"},  32'(coeff_wr_en),   32'd0);
    check({tag, "_busy"},   32'(busy),          32'd0);
    check({tag, "_done"},   32'(done),          32'd0);
    check({tag, "_abort"},  32'(aborted),       32'd0);
    check({tag, "_forced"}, 32'(forced_commit), 32'd0);
    check({tag, "_verr"},   32'(verify_err),    32'd0);
    check({tag, "_state"},  32'(o_dbg_state),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0;
    cfg_data = '0; filt_valid_in = 1'b0; coeff_rb = '0;
    wr_prev = 1'b0; corrupt5 = 1'b0;
    for (int k = 0; k < N; k++) exp_bank[k] = '0;

    // Reset state
    #12;
    check_idle_outputs("rst");
    check_bank("rst_bank");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Nominal load with taps k+1 and filt_valid_in low. A stray cfg_start at
    // tap 10 must be ignored.
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    check("t1_ready", 32'(cfg_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    load_taps(N, 1, 10);
    check("t1_ready_wait", 32'(cfg_ready), 32'd0);
    check("t1_busy_wait", 32'(busy), 32'd1);
    finish_load(2, 1'b0, "t1");
    check("t1_wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_verr", 32'(verify_err), 32'd0);
    check("t1_forced", 32'(forced_commit), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check_bank("t1_bank");

    // filt_valid_in held high: forced commit after the wait times out
    filt_valid_in = 1'b1;
    pulse_start();
    load_taps(N, 1, -1);
    finish_load(TO + 1, 1'b0, "t2");
    check("t2_forced", 32'(forced_commit), 32'd1);
    check("t2_verr", 32'(verify_err), 32'd0);
    filt_valid_in = 1'b0;
    tick();
    check("t2_forced_sticky", 32'(forced_commit), 32'd1);

    // Abort together with the handshake of tap 40
    pulse_start();
    check("t3_forced_clr", 32'(forced_commit), 32'd0);
    w0 = wr_cnt; a0 = abort_cnt;
    load_taps(40, 100, -1);
    cfg_valid = 1'b1; cfg_data = 20'h00777; cfg_abort = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_abort = 1'b0;
    check("t3_aborted", 32'(aborted), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ready", 32'(cfg_ready), 32'd0);
    check_bank("t3_bank");
    repeat (3) tick();
    check("t3_aborted_pulse", 32'(aborted), 32'd0);
    check("t3_abort_count", 32'(abort_cnt - a0), 32'd1);
    check("t3_no_wr", 32'(wr_cnt - w0), 32'd0);

    // Corrupted readback of tap 5. cfg_abort held during COMMIT/VERIFY is ignored.
    corrupt5 = 1'b1;
    a0 = abort_cnt;
    pulse_start();
    load_taps(N, 1, -1);
    finish_load(2, 1'b1, "t4");
    check("t4_verr", 32'(verify_err), 32'(VER));
    check("t4_no_abort", 32'(abort_cnt - a0), 32'd0);
    check("t4_shadow5", 32'(coeff_bank[5*W +: W]), 32'h6);
    corrupt5 = 1'b0;
    pulse_start();
    check("t4_verr_clr", 32'(verify_err), 32'd0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("t4_abort_load", 32'(busy), 32'd0);

    // Abort while in WAIT_SAFE
    filt_valid_in = 1'b1;
    pulse_start();
    load_taps(N, 1, -1);
    repeat (2) tick();
    check("t5_state_wait", 32'(o_dbg_state), 32'd2);
    w0 = wr_cnt;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("t5_aborted", 32'(aborted), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    check("t5_no_wr", 32'(wr_cnt - w0), 32'd0);

    // Reset asserted in WAIT_SAFE
    pulse_start();
    load_taps(N, 1, -1);
    repeat (4) tick();
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) exp_bank[k] = '0;
    check_idle_outputs("t6_rst");
    check_bank("t6_bank");
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; a0 = abort_cnt;
    repeat (25) tick();
    check("t6_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_no_abort", 32'(abort_cnt - a0), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    filt_valid_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coeff_load_ctrl.md
COEFF_LOAD_CTRL -- requirements
Module: coeff_load_ctrl

Interface
REQ-001 Parameter COEFF_WIDTH, default 20: coefficient word width, S20.18.
REQ-002 Parameter N_TAP, default 72: number of coefficients per bank.
REQ-003 Parameter SAFE_TIMEOUT, default 16: maximum WAIT_SAFE cycles before a forced commit.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_start  input  1  request a new bank load.
REQ-007 cfg_abort  input  1  cancel the load in progress.
REQ-008 cfg_valid  input  1  cfg_data is valid.
REQ-009 cfg_ready  output  1  controller accepts cfg_data.
REQ-010 cfg_data  input  COEFF_WIDTH  coefficient, signed; taps are sent in order 0..N_TAP-1.
REQ-011 filt_valid_in  input  1  the decimator's sample strobe, used for commit safety.
REQ-012 coeff_rb  input  COEFF_WIDTH x N_TAP  coefficient readback from the decimator.
REQ-013 coeff_bank  output  COEFF_WIDTH x N_TAP  shadow bank, driven to the decimator's coefficient input.
REQ-014 coeff_wr_en  output  1  registered single-cycle commit strobe.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 done  output  1  one-cycle pulse when a load completes.
REQ-017 aborted  output  1  one-cycle pulse when a load is cancelled.
REQ-018 forced_commit  output  1  sticky; commit happened on timeout.
REQ-019 verify_err  output  1  sticky; readback mismatch.

Function
REQ-020 FSM states: IDLE, LOAD, WAIT_SAFE, COMMIT, VERIFY.
REQ-021 IDLE: on cfg_start go to LOAD, set the tap index to 0, and clear forced_commit and verify_err.
REQ-022 cfg_start is ignored outside IDLE; cfg_abort is ignored in IDLE.
REQ-023 cfg_ready is 1 only in LOAD; a handshake (cfg_valid && cfg_ready) writes shadow[idx] and increments idx.
REQ-024 A handshake at idx == N_TAP-1 moves LOAD to WAIT_SAFE; the index never wraps.
REQ-025 WAIT_SAFE: the wait counter starts at 0.
  - If filt_valid_in == 0 in a cycle, go to COMMIT next cycle.
  - If the counter reaches SAFE_TIMEOUT-1 with filt_valid_in still high, go to COMMIT and set forced_commit.
REQ-026 COMMIT lasts exactly one cycle with coeff_wr_en = 1; coeff_wr_en is 0 in every other state.
REQ-027 VERIFY (one cycle): compare coeff_rb against the shadow element-wise; any mismatch sets verify_err. Then go to IDLE and pulse done in the next cycle.
REQ-028 cfg_abort in LOAD or WAIT_SAFE returns to IDLE next cycle and pulses aborted.
  - No coeff_wr_en is issued.
  - Shadow contents written so far are retained.
  - Abort has priority over a same-cycle handshake, which is then not written.
REQ-029 cfg_abort in COMMIT or VERIFY is ignored.
REQ-030 coeff_bank always reflects the shadow registers; the shadow changes only via LOAD handshakes.
REQ-031 Minimum latency from the last handshake edge: coeff_wr_en high in cycle +2, done high in cycle +4.

Reset
REQ-032 Asynchronous reset drives the following:
  - FSM to IDLE; idx and wait counter to 0.
  - Shadow bank all zero.
  - cfg_ready, coeff_wr_en, busy, done, aborted, forced_commit and verify_err all 0.
REQ-033 Reset asserted mid-load or mid-commit aborts silently: no done pulse, no aborted pulse, no coeff_wr_en after deassertion.

Configuration
REQ-034 Macro COEFF_LOAD_VERIFY_EN.
  - Defined: the VERIFY state and readback compare exist as specified.
  - Undefined: COMMIT goes directly to IDLE, done pulses one cycle earlier (+3), verify_err is tied 0, and coeff_rb is unused.

Verification
REQ-035 Load taps k = 0..71 with value k+1, filt_valid_in = 0, coeff_rb looped back one cycle after coeff_wr_en -> coeff_bank[k] = k+1, exactly one coeff_wr_en pulse, done pulses, verify_err = 0.
REQ-036 Same load with filt_valid_in held high for 20 cycles after the last tap -> coeff_wr_en on wait cycle 16, forced_commit = 1.
REQ-037 cfg_abort asserted together with the handshake of tap 40 -> aborted pulses, taps 0..39 written and tap 40 not, no coeff_wr_en, busy = 0 next cycle.
REQ-038 Readback of tap 5 forced to 20'sh00000 while the shadow holds 20'sh00006 -> verify_err = 1 and done still pulses; verify_err clears on the next cfg_start.
REQ-039 cfg_start pulsed while in LOAD at tap 10 -> ignored, and the load completes normally with 72 taps.
REQ-040 rst_n asserted in WAIT_SAFE -> all outputs 0, shadow zero, no coeff_wr_en after release.
